soft_error_event_arbiter: RTL and testbench

- Sits downstream of the per-bank soft-error aggregator, which produces one registered OR-reduced error bit per bank per channel (A and B).
- Turns the level error vectors into discrete timestamped events and keeps per-source saturating counters.
- Shares one event output port among all 2*ERRSIG_ID_num sources with a round-robin arbiter and a valid/ready handshake.
- Feeds the readout/logging path (UART/host FIFO).

---
 rtl/soft_error_pkg.sv | 29 ++
 rtl/soft_error_rr_arbiter.sv | 52 +++++
 rtl/soft_error_event_arbiter.sv | 162 ++++++++++++++++
 tb/tb_soft_error_event_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soft_error_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soft_error_pkg
// Description : Shared constants for the soft-error event arbiter: source
//               count and index widths for the default bank count, the
//               channel-type encoding and the output FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package soft_error_pkg;

    localparam int ERRSIG_ID_NUM_DEF = 7;

    // Each bank contributes one channel-A and one channel-B source.
    function automatic int src_num(input int banks);
        return 2 * banks;
    endfunction

    localparam int SRC_NUM = src_num(ERRSIG_ID_NUM_DEF);
    localparam int BANK_W  = $clog2(ERRSIG_ID_NUM_DEF);
    localparam int SRC_W   = $clog2(SRC_NUM);

    localparam logic EVT_TYPE_A = 1'b0;
    localparam logic EVT_TYPE_B = 1'b1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/soft_error_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soft_error_rr_arbiter
// Description : Combinational round-robin selector. Returns the first set
//               request at or above the pointer, wrapping past SRC_NUM-1.
// Ports       : i_req     - request vector, one bit per source
//               i_ptr     - index with highest priority this cycle
//               o_grant   - selected source index (0 when nothing requested)
//               o_any_req - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module soft_error_rr_arbiter
    import soft_error_pkg::*;
#(
    parameter int SRC_NUM = soft_error_pkg::SRC_NUM,
    parameter int SRC_W   = $clog2(SRC_NUM)
) (
    input  logic [SRC_NUM-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [SRC_W-1:0]   o_grant,
    output logic               o_any_req
);

    logic [SRC_W-1:0] w_idx;

    // Index of the source 'off' positions after 'base', modulo SRC_NUM.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= SRC_NUM) begin
            sum = sum - SRC_NUM;
        end
        return SRC_W'(sum);
    endfunction

    // Walk from the farthest offset down to the pointer itself so that the
    // last hit written is the closest one to the pointer.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int off = SRC_NUM - 1; off >= 0; off--) begin
            w_idx = wrap_add(i_ptr, off);
            if (i_req[w_idx]) begin
                o_grant   = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/soft_error_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soft_error_event_arbiter
// Description : Converts per-bank A/B error levels into timestamped events,
//               keeps a saturating counter per source and serialises pending
//               events onto one valid/ready port with round-robin fairness.
//               Source index s = 2*bank + type.
// Ports       : i_clk, i_rst          - clock, async active-high reset
//               i_err_A, i_err_B      - per-bank error levels
//               i_clear               - sync clear of counters and overflow
//               o_evt_valid/i_evt_ready, o_evt_bank, o_evt_type, o_evt_ts
//                                     - event record and handshake
//               i_cnt_sel, o_cnt_A, o_cnt_B
//                                     - registered counter readout per bank
//               o_overflow            - sticky lost-event flag
// Revision    : 1.0 - initial release
// ============================================================================
module soft_error_event_arbiter
    import soft_error_pkg::*;
#(
    parameter int ERRSIG_ID_num = ERRSIG_ID_NUM_DEF,
    parameter int TS_WIDTH      = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [ERRSIG_ID_num-1:0]         i_err_A,
    input  logic [ERRSIG_ID_num-1:0]         i_err_B,
    input  logic                             i_clear,
    output logic                             o_evt_valid,
    input  logic                             i_evt_ready,
    output logic [$clog2(ERRSIG_ID_num)-1:0] o_evt_bank,
    output logic                             o_evt_type,
    output logic [TS_WIDTH-1:0]              o_evt_ts,
    input  logic [$clog2(ERRSIG_ID_num)-1:0] i_cnt_sel,
    output logic [CNT_WIDTH-1:0]             o_cnt_A,
    output logic [CNT_WIDTH-1:0]             o_cnt_B,
    output logic                             o_overflow
);

    localparam int c_SRC_NUM = src_num(ERRSIG_ID_num);
    localparam int c_BANK_W  = $clog2(ERRSIG_ID_num);
    localparam int c_SRC_W   = c_BANK_W + 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [c_SRC_NUM-1:0] w_in;
    logic [c_SRC_NUM-1:0] w_rise;
    logic [c_SRC_NUM-1:0] w_gnt_hit;
    logic [c_SRC_NUM-1:0] w_ovf_hit;
    logic [c_SRC_NUM-1:0] r_prev;
    logic [c_SRC_NUM-1:0] r_pend;
    logic [TS_WIDTH-1:0]  r_ts  [c_SRC_NUM];
    logic [CNT_WIDTH-1:0] r_cnt [c_SRC_NUM];
    logic [TS_WIDTH-1:0]  r_tsc;
    logic [c_SRC_W-1:0]   r_ptr;
    logic [c_SRC_W-1:0]   w_grant;
    logic                 w_any;
    logic                 w_load;
    logic [0:0]           r_state;

    // Interleave channels so that bit 0 of the source index is the type.
    for (genvar s = 0; s < c_SRC_NUM; s++) begin : g_src
        if (s % 2 == 0) begin : g_chan_a
            assign w_in[s] = i_err_A[s/2];
        end else begin : g_chan_b
            assign w_in[s] = i_err_B[s/2];
        end
        assign w_gnt_hit[s] = w_load && (w_grant == c_SRC_W'(s));
        // A record being granted this cycle is not lost by a fresh rise.
        assign w_ovf_hit[s] = w_rise[s] && r_pend[s] && !w_gnt_hit[s];
    end

    assign w_rise = w_in & ~r_prev;

    soft_error_rr_arbiter #(
        .SRC_NUM (c_SRC_NUM),
        .SRC_W   (c_SRC_W)
    ) u_rr_arbiter (
        .i_req     (r_pend),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_any_req (w_any)
    );

    // In HOLD the valid flag is always set, so ready alone is the handshake.
    assign w_load = w_any && ((r_state == IDLE) || i_evt_ready);

    // Edge detection, pending flags, timestamps, counters and overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev     <= '0;
            r_pend     <= '0;
            r_tsc      <= '0;
            o_overflow <= 1'b0;
            for (int s = 0; s < c_SRC_NUM; s++) begin
                r_ts[s]  <= '0;
                r_cnt[s] <= '0;
            end
        end else begin
            r_prev <= w_in;
            r_tsc  <= r_tsc + TS_WIDTH'(1);
            for (int s = 0; s < c_SRC_NUM; s++) begin
                // A rise wins over a grant: the old record goes out while
                // the new one stays pending with its own timestamp.
                if (w_rise[s]) begin
                    r_pend[s] <= 1'b1;
                    r_ts[s]   <= r_tsc;
                end else if (w_gnt_hit[s]) begin
                    r_pend[s] <= 1'b0;
                end
                if (i_clear) begin
                    r_cnt[s] <= w_rise[s] ? CNT_WIDTH'(1) : '0;
                end else if (w_rise[s] && (r_cnt[s] != c_CNT_MAX)) begin
                    r_cnt[s] <= r_cnt[s] + CNT_WIDTH'(1);
                end
            end
            if (i_clear) begin
                o_overflow <= 1'b0;
            end else if (|w_ovf_hit) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Output record FSM and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            o_evt_valid <= 1'b0;
            o_evt_bank  <= '0;
            o_evt_type  <= EVT_TYPE_A;
            o_evt_ts    <= '0;
        end else if (w_load) begin
            r_state     <= HOLD;
            o_evt_valid <= 1'b1;
            o_evt_bank  <= w_grant[c_SRC_W-1:1];
            o_evt_type  <= w_grant[0] ? EVT_TYPE_B : EVT_TYPE_A;
            o_evt_ts    <= r_ts[w_grant];
            r_ptr       <= (w_grant == c_SRC_W'(c_SRC_NUM - 1)) ? '0 : w_grant + c_SRC_W'(1);
        end else if ((r_state == HOLD) && i_evt_ready) begin
            r_state     <= IDLE;
            o_evt_valid <= 1'b0;
        end
    end

    // Counter readout; bank indices beyond the last bank read as zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt_A <= '0;
            o_cnt_B <= '0;
        end else if (int'(i_cnt_sel) < ERRSIG_ID_num) begin
            o_cnt_A <= r_cnt[{i_cnt_sel, EVT_TYPE_A}];
            o_cnt_B <= r_cnt[{i_cnt_sel, EVT_TYPE_B}];
        end else begin
            o_cnt_A <= '0;
            o_cnt_B <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soft_error_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_soft_error_event_arbiter
// Description : Self-checking bench for soft_error_event_arbiter. Uses an
//               8-bit counter width so saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soft_error_event_arbiter;

    localparam int N    = 7;
    localparam int S    = 2 * N;
    localparam int TW   = 32;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [N-1:0]  err_a   = '0;
    logic [N-1:0]  err_b   = '0;
    logic          clear   = 1'b0;
    logic          ready   = 1'b0;
    logic [2:0]    cnt_sel = '0;
    logic          evt_valid;
    logic [2:0]    evt_bank;
    logic          evt_type;
    logic [TW-1:0] evt_ts;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic          overflow;

    int errs   = 0;
    int checks = 0;
    int hs_cnt = 0;
    logic [TW-1:0] cyc = '0;

    soft_error_event_arbiter #(
        .ERRSIG_ID_num (N),
        .TS_WIDTH      (TW),
        .CNT_WIDTH     (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_err_A     (err_a),
        .i_err_B     (err_b),
        .i_clear     (clear),
        .o_evt_valid (evt_valid),
        .i_evt_ready (ready),
        .o_evt_bank  (evt_bank),
        .o_evt_type  (evt_type),
        .o_evt_ts    (evt_ts),
        .i_cnt_sel   (cnt_sel),
        .o_cnt_A     (cnt_a),
        .o_cnt_B     (cnt_b),
        .o_overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit            m_prev [S];
    bit            m_pend [S];
    logic [TW-1:0] m_ts   [S];
    int            m_cnt  [S];
    logic [TW-1:0] m_tsc;
    int            m_ptr;
    bit            m_valid;
    int            m_src;
    logic [TW-1:0] m_rec_ts;
    bit            m_ovf;
    int            m_cnt_a;
    int            m_cnt_b;

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            m_prev[s] = 0; m_pend[s] = 0; m_ts[s] = '0; m_cnt[s] = 0;
        end
        m_tsc = '0; m_ptr = 0; m_valid = 0; m_src = 0; m_rec_ts = '0;
        m_ovf = 0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    task automatic model_step();
        bit in_now [S];
        bit rise   [S];
        int g;
        int idx;
        int sel;
        bit ovf_set;
        for (int s = 0; s < S; s++) begin
            in_now[s] = (s % 2 == 0) ? err_a[s/2] : err_b[s/2];
            rise[s]   = in_now[s] && !m_prev[s];
        end
        sel     = int'(cnt_sel);
        m_cnt_a = (sel < N) ? m_cnt[2*sel]     : 0;
        m_cnt_b = (sel < N) ? m_cnt[2*sel + 1] : 0;
        // The output slot can take a new record when empty or being consumed.
        g = -1;
        if (!m_valid || ready) begin
            for (int k = 0; k < S; k++) begin
                idx = (m_ptr + k) % S;
                if (g < 0 && m_pend[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            m_valid  = 1;
            m_src    = g;
            m_rec_ts = m_ts[g];
            m_pend[g] = 0;
            m_ptr    = (g + 1) % S;
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
        ovf_set = 0;
        for (int s = 0; s < S; s++) begin
            if (rise[s]) begin
                if (m_pend[s]) ovf_set = 1;
                m_pend[s] = 1;
                m_ts[s]   = m_tsc;
                m_cnt[s]  = clear ? 1 : ((m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX);
            end else if (clear) begin
                m_cnt[s] = 0;
            end
        end
        m_ovf = clear ? 1'b0 : (m_ovf || ovf_set);
        m_tsc = m_tsc + 1;
        for (int s = 0; s < S; s++) m_prev[s] = in_now[s];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            cyc = '0;
        end else begin
            model_step();
            cyc = cyc + 1;
        end
    end

    // Scoreboard against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && ready) hs_cnt++;
            check("sb_valid", evt_valid, m_valid);
            if (m_valid) begin
                check("sb_bank", evt_bank, m_src / 2);
                check("sb_type", evt_type, m_src % 2);
                check("sb_ts", evt_ts, m_rec_ts);
            end
            check("sb_overflow", overflow, m_ovf);
            check("sb_cnt_a", cnt_a, m_cnt_a);
            check("sb_cnt_b", cnt_b, m_cnt_b);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1; err_a = '0; err_b = '0; clear = 1'b0; ready = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic check_rec(input string name, input int bank, input int typ, input logic [TW-1:0] ts);
        check({name, "_valid"}, evt_valid, 1);
        check({name, "_bank"}, evt_bank, bank);
        check({name, "_type"}, evt_type, typ);
        check({name, "_ts"}, evt_ts, ts);
    endtask

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           hold;
        int           bank;
        int           typ;
        int           cnt;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [TW-1:0] e;
        logic [TW-1:0] e2;
        int base;
        int nrec;
        bit found;

        tbl[0] = '{7'h08, 7'h00, 5, 3, 0, 1};
        tbl[1] = '{7'h00, 7'h04, 1, 2, 1, 1};
        tbl[2] = '{7'h40, 7'h00, 2, 6, 0, 1};
        tbl[3] = '{7'h08, 7'h00, 1, 3, 0, 2};
        tbl[4] = '{7'h00, 7'h01, 3, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", evt_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_cnt_a", cnt_a, 0);
        check("reset_cnt_b", cnt_b, 0);
        #2 rst = 1'b0;
        tick();

        // Single-source events, one record each.
        for (int i = 0; i < 5; i++) begin
            ready   = 1'b1;
            cnt_sel = 3'(tbl[i].bank);
            base    = hs_cnt;
            e       = cyc;
            err_a   = tbl[i].a;
            err_b   = tbl[i].b;
            for (int c = 0; c < tbl[i].hold + 6; c++) begin
                if (c == tbl[i].hold) begin
                    err_a = '0;
                    err_b = '0;
                end
                tick();
                if (c == 1) check_rec("tbl_rec", tbl[i].bank, tbl[i].typ, e);
            end
            check("tbl_records", hs_cnt - base, 1);
            check("tbl_cnt", (tbl[i].typ == 0) ? cnt_a : cnt_b, tbl[i].cnt);
        end

        // Simultaneous rises from reset pointer: back-to-back in index order.
        do_reset();
        ready = 1'b1;
        e     = cyc;
        err_a = 7'h41;
        err_b = 7'h01;
        tick();
        err_a = '0;
        err_b = '0;
        tick(); check_rec("burst0", 0, 0, e);
        tick(); check_rec("burst1", 0, 1, e);
        tick(); check_rec("burst2", 6, 0, e);
        tick(); check("burst_end_valid", evt_valid, 0);

        // Stalled consumer; second rise on a queued source overflows.
        ready   = 1'b0;
        cnt_sel = 3'd4;
        e       = cyc;
        e2      = '0;
        err_a   = 7'h10;
        err_b   = 7'h10;
        tick();
        err_a = '0;
        err_b = '0;
        tick(); check_rec("hold_first", 4, 0, e);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin err_b = 7'h10; e2 = cyc; end
            if (c == 3) err_b = '0;
            tick();
            check_rec("hold_stable", 4, 0, e);
        end
        check("hold_overflow", overflow, 1);
        check("hold_cnt_b", cnt_b, 2);
        ready = 1'b1;
        tick(); check_rec("hold_second", 4, 1, e2);
        tick(); check("hold_end_valid", evt_valid, 0);

        // Counter saturation, then clear together with a new rise.
        cnt_sel = 3'd2;
        for (int i = 0; i < 300; i++) begin
            err_b = 7'h04; tick();
            err_b = 7'h00; tick();
        end
        repeat (4) tick();
        check("sat_cnt_b", cnt_b, CMAX);
        err_b = 7'h04;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        check("clear_cnt_b", cnt_b, 1);
        check("clear_overflow", overflow, 0);
        err_b = '0;
        repeat (4) tick();

        // Fairness against a constantly re-triggering source.
        nrec  = 0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            err_a[0] = (c % 2 == 0);
            if (c == 3) err_b[5] = 1'b1;
            tick();
            if (c >= 4 && !found && evt_valid) begin
                nrec++;
                if (evt_bank == 3'd5 && evt_type == 1'b1) found = 1;
            end
        end
        check("fair_found", found, 1);
        check("fair_within_two", (nrec <= 2), 1);
        err_a = '0;
        err_b = '0;
        repeat (4) tick();

        // Asynchronous reset while a record is held.
        ready = 1'b0;
        err_a = 7'h02;
        tick();
        tick();
        check("arst_pre_valid", evt_valid, 1);
        #2;
        rst   = 1'b1;
        err_a = '0;
        #1;
        check("arst_valid", evt_valid, 0);
        check("arst_cnt_a", cnt_a, 0);
        check("arst_cnt_b", cnt_b, 0);
        check("arst_overflow", overflow, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            tick();
            check("arst_idle_valid", evt_valid, 0);
            check("arst_rd_a", cnt_a, 0);
            check("arst_rd_b", cnt_b, 0);
        end

        // Randomised traffic checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            err_a   = err_a ^ (7'($urandom) & 7'($urandom));
            err_b   = err_b ^ (7'($urandom) & 7'($urandom));
            ready   = ($urandom_range(0, 2) != 0);
            clear   = ($urandom_range(0, 63) == 0);
            cnt_sel = 3'($urandom);
            tick();
        end
        err_a = '0;
        err_b = '0;
        clear = 1'b0;
        ready = 1'b1;
        repeat (40) tick();
        check("drain_valid", evt_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
